priority_encode_module: RTL
===========================

PRIORITY_ENCODE_MODULE -- requirements
Module: priority_encode_module

Interface
REQ-001 Parameter: PRIO_HIGH, default 1, 1 = highest set index wins, 0 = lowest set index wins.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 req  input  8  event strobes, one per source; any bit high for one cycle is an event.
REQ-005 ready  input  1  consumer accepts the presented code this cycle.
REQ-006 valid  output  1  code holds a pending source index.
REQ-007 code  output  3  binary index of the granted source, 0..7.
REQ-008 pend  output  8  current sticky pending register.
REQ-009 pend_cnt  output  4  number of bits set in pend, 0..8.

Function
REQ-010 Each clk edge SHALL update pend to (pend & ~clr_mask) | req, where clr_mask is the one-hot decode of code when valid && ready, else 0.
REQ-011 A req bit equal to the bit being cleared in the same cycle SHALL leave that pend bit set: the new event wins over the clear.
REQ-012 The FSM SHALL have two states, IDLE and HOLD, encoded in the shared package.
REQ-013 In IDLE with pend != 0, the block SHALL load code with the priority index of pend per PRIO_HIGH, set valid=1, and enter HOLD at that edge.
REQ-014 In IDLE with pend == 0, the block SHALL stay in IDLE with valid=0.
REQ-015 Latency: req high in cycle N SHALL give pend set after edge N and valid=1 after edge N+1, provided no other source is held.
REQ-016 In HOLD, code and valid SHALL stay stable until a cycle with ready=1; higher-priority arrivals SHALL NOT preempt the presented code.
REQ-017 In HOLD with ready=1, the block SHALL clear the granted pend bit per REQ-010. If the remaining pend (after merge with req) is nonzero, it SHALL load the next priority index, keep valid=1 and stay in HOLD. Otherwise it SHALL set valid=0 and return to IDLE.
REQ-018 This gives back-to-back grants: with ready held at 1, one code SHALL be accepted per cycle with no idle bubble.
REQ-019 ready while valid=0 SHALL be ignored and SHALL clear nothing.
REQ-020 pend_cnt SHALL be the registered popcount of the next pend value, coherent with pend in the same cycle; a value of 8 (all pending) SHALL be representable.
REQ-021 Repeated req on an already pending bit SHALL be absorbed: there is no counting and no overflow indication.
REQ-022 code SHALL retain its last value while valid=0.

Reset
REQ-023 With rst=1 at a clk edge: pend=0, pend_cnt=0, valid=0, code=0, state=IDLE.
REQ-024 rst has priority over req and ready in the same cycle. Events present during reset SHALL be discarded.
REQ-025 A reset asserted while in HOLD SHALL drop the presented code without any acceptance.

Structure
REQ-026 A shared package SHALL hold the constants N_REQ=8 and CODE_W=3, the state enum {IDLE, HOLD}, and a one-hot-decode function of width N_REQ.
REQ-027 A combinational sub-module, prio_find, SHALL map an 8-bit vector and PRIO_HIGH to a 3-bit index plus a found flag. It is instantiated once, on the merged next-pend value.
REQ-028 All outputs SHALL be registered. There is no combinational path from req or ready to valid or code.

Verification
REQ-029 Reset: drive rst=1 with req=8'hFF for 2 cycles, then release -> valid=0, pend=0, pend_cnt=0 after release.
REQ-030 Single event: req=8'h20 for one cycle -> pend=8'h20 next cycle, then valid=1 and code=5; ready=1 -> valid=0, pend=0.
REQ-031 Priority and stability, PRIO_HIGH=1: req=8'h11, ready=0; then req=8'h80 while code=4 -> code stays 4. Then hold ready=1 -> codes accepted in order 4, 7, 0, on consecutive cycles.
REQ-032 PRIO_HIGH=0: req=8'hA0 -> code=5 first, then 7.
REQ-033 Simultaneous event: with code=3 valid, drive ready=1 and req=8'h08 together -> pend bit 3 remains set, and code 3 is presented again next.
REQ-034 Mid-operation reset: pend=8'hFF and valid=1 with code=7, assert rst for 1 cycle -> all outputs reach reset values, and no grant follows until new req.

Source files
------------

// File: rtl/priority_encode_module_pkg.sv
// Shared constants, FSM state type and bit-vector helpers for the priority encoder.
package priority_encode_module_pkg;

  localparam int unsigned N_REQ  = 8;
  localparam int unsigned CODE_W = 3;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // One-hot decode of a source index into an N_REQ-wide mask.
  function automatic logic [N_REQ-1:0] onehot(input logic [CODE_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Count of set bits; CNT_W is wide enough to hold N_REQ itself.
  function automatic logic [CNT_W-1:0] popcount(input logic [N_REQ-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/priority_encode_module_prio_find.sv
// Combinational priority search: index of the highest (or lowest) set bit.
module prio_find
  import priority_encode_module_pkg::*;
#(
  parameter bit PRIO_HIGH = 1'b1
) (
  input  logic [N_REQ-1:0]  vec,
  output logic [CODE_W-1:0] idx,
  output logic              found
);

  // Later loop iterations overwrite earlier ones, so the winning end is visited last.
  always_comb begin
    idx   = '0;
    found = |vec;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (PRIO_HIGH) begin
        if (vec[i]) idx = CODE_W'(i);
      end else begin
        if (vec[N_REQ-1-i]) idx = CODE_W'(N_REQ - 1 - i);
      end
    end
  end

endmodule

// File: rtl/priority_encode_module.sv
// Sticky event collector that presents one pending source index at a time with valid/ready.
module priority_encode_module
  import priority_encode_module_pkg::*;
#(
  parameter bit PRIO_HIGH = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic              ready,
  output logic              valid,
  output logic [CODE_W-1:0] code,
  output logic [N_REQ-1:0]  pend,
  output logic [CNT_W-1:0]  pend_cnt
);

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  clr_mask;
  logic [N_REQ-1:0]  pend_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              valid_d;
  logic [CODE_W-1:0] code_d;
  logic [CODE_W-1:0] find_idx;
  logic              find_ok;
  // Priority index of the current pend, captured alongside it so IDLE needs no second search.
  logic [CODE_W-1:0] top_q;

  prio_find #(
    .PRIO_HIGH (PRIO_HIGH)
  ) u_find (
    .vec   (pend_d),
    .idx   (find_idx),
    .found (find_ok)
  );

  // Merge: clear the accepted bit first, then OR in new events so an event wins over its clear.
  always_comb begin
    clr_mask = '0;
    if (valid && ready) clr_mask = onehot(code);
    pend_d = (pend & ~clr_mask) | req;
    cnt_d  = popcount(pend_d);
  end

  // Next-state and presented-code logic.
  always_comb begin
    state_d = state_q;
    valid_d = valid;
    code_d  = code;
    unique case (state_q)
      IDLE: begin
        if (|pend) begin
          code_d  = top_q;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (ready) begin
          if (find_ok) begin
            code_d = find_idx;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pend     <= '0;
      pend_cnt <= '0;
      valid    <= 1'b0;
      code     <= '0;
      top_q    <= '0;
    end else begin
      state_q  <= state_d;
      pend     <= pend_d;
      pend_cnt <= cnt_d;
      valid    <= valid_d;
      code     <= code_d;
      top_q    <= find_idx;
    end
  end

endmodule
